multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback over several clocks.
- Drives the shared-ALU operand muxes and the 2-bit alu_op consumed by the ALU decoder (00 add, 01 sub, 10 funct-decoded).
- Drives all architectural write enables and waits on the memory ready handshake.

Parameters:
- STALL_LIMIT, 15: maximum consecutive cycles waiting on mem_ready in a memory state before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- alu_op  out  2  to ALU decoder
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
- result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result
- adr_src  out  1  0 PC, 1 result
- ir_write  out  1  load IR and oldPC
- pc_write  out  1  equals pc_update OR (branch AND zero)
- reg_write  out  1  register file write
- mem_write  out  1  data memory write
- instr_done  out  1  1-cycle pulse on an instruction's last cycle
- illegal_op  out  1  1-cycle pulse in DECODE on an unsupported opcode
- mem_err  out  1  1-cycle pulse on stall timeout
- state_dbg  out  4  current state encoding

Behaviour:
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11-15 go to FETCH on the next edge.
- Moore outputs decode from state; mem_ready and zero gate only the signals noted. Every output not listed for a state is 0.
- Reset: while rst_n=0, state=FETCH and the stall counter is 0. ir_write, pc_write, reg_write, mem_write and all pulses are forced to 0 asynchronously. Mux selects take their FETCH values. Reset asserted mid-instruction aborts it with no partial write.
- FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write and pc_update are asserted only when mem_ready=1. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: a=01, b=01, alu_op=00. Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other -> FETCH, with illegal_op=1 and instr_done=1
- MEMADR: a=10, b=01, alu_op=00. Goes to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Waits for mem_ready=1, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Goes to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write held at 1 while waiting. On mem_ready=1 sets instr_done=1 and goes to FETCH.
- EXECR: a=10, b=00, alu_op=10. Goes to ALUWB.
- EXECI: a=10, b=01, alu_op=10. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Goes to FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1, so pc_write=zero. instr_done=1. Goes to FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1. Goes to ALUWB.
- Stall counter, 4 bits minimum:
  - Counts each cycle in FETCH, MEMREAD or MEMWRITE while mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - When STALL_LIMIT≠0 and the count reaches STALL_LIMIT with mem_ready still 0: mem_err=1 and instr_done=1 for that cycle, write enables forced to 0 for that cycle, next state FETCH.
  - mem_ready=1 in the limit cycle wins: normal completion, no mem_err.
- Latency with mem_ready=1 throughout, counting FETCH through instr_done:
  - R-type, I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles

Test Plan:
- Reset release, mem_ready=1, opcode=0110011 → state_dbg 0,1,6,8,0. alu_op=10 in EXECR. reg_write=1 and instr_done=1 only in ALUWB. ir_write=1 only in FETCH.
- opcode=0000011, mem_ready low for 2 cycles in MEMREAD → MEMREAD lasts 3 cycles. reg_write=1 in MEMWB with result_src=01. No mem_err.
- opcode=1100011: first zero=1, then zero=0 on a second beq → pc_write=1 in BEQ for the first, 0 for the second. alu_op=01 in both.
- opcode=0000000 → illegal_op and instr_done pulse in DECODE. Next state FETCH. No write enables asserted.
- STALL_LIMIT=3, opcode=0100011, mem_ready held 0 in MEMWRITE → mem_err on the 3rd waiting cycle. mem_write=0 in that cycle. Next state FETCH.
- rst_n dropped mid-MEMWRITE → mem_write falls to 0 with no clock edge. state_dbg=0. After release, a normal fetch proceeds.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main control FSM of the multicycle RV32I core. Each instruction is walked
// through FETCH, DECODE and a class-specific tail (memory, ALU or branch)
// over several clocks. The FSM drives the shared-ALU operand muxes, the
// 2-bit alu_op consumed by the ALU decoder, every architectural write enable,
// and waits on the memory ready handshake with an optional stall timeout.
//
// Parameters:
//   STALL_LIMIT  consecutive not-ready cycles tolerated in a memory-wait state
//                before the access is aborted (0 = wait forever)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   opcode      in   instr[6:0] from the instruction register
//   zero        in   ALU zero flag (only consulted in BEQ)
//   mem_ready   in   memory access completes this cycle
//   alu_op      out  00 add, 01 sub, 10 funct-decoded
//   alu_src_a   out  00 PC, 01 oldPC, 10 rs1
//   alu_src_b   out  00 rs2, 01 imm, 10 constant 4
//   result_src  out  00 ALUOut, 01 memory data, 10 ALU result
//   adr_src     out  memory address: 0 PC, 1 result
//   ir_write    out  load IR and oldPC
//   pc_write    out  pc_update OR (branch AND zero)
//   reg_write   out  register file write
//   mem_write   out  data memory write
//   instr_done  out  1-cycle pulse on an instruction's last cycle
//   illegal_op  out  1-cycle pulse in DECODE on an unsupported opcode
//   mem_err     out  1-cycle pulse on a stall timeout
//   state_dbg   out  current state encoding
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned STALL_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state_dbg
);

    // -------------------------------------------------------------------------
    // Encodings
    // -------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] A_PC      = 2'b00;
    localparam logic [1:0] A_OLDPC   = 2'b01;
    localparam logic [1:0] A_RS1     = 2'b10;

    localparam logic [1:0] B_RS2     = 2'b00;
    localparam logic [1:0] B_IMM     = 2'b01;
    localparam logic [1:0] B_FOUR    = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Counter is at least 4 bits and grows if the limit needs more.
    localparam int CNT_W = (STALL_LIMIT < 16) ? 4 : $clog2(STALL_LIMIT + 1);
    localparam bit TIMEOUT_EN = (STALL_LIMIT != 0);
    // The timeout fires in the cycle that would be the STALL_LIMIT-th
    // not-ready cycle, i.e. when the count of previous waits is LIMIT-1.
    localparam logic [CNT_W-1:0] STALL_LAST =
        CNT_W'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    // Ungated versions of the write enables and pulses; reset gating is
    // applied at the ports.
    logic ir_write_c;
    logic pc_update_c;
    logic branch_c;
    logic reg_write_c;
    logic mem_write_c;
    logic done_c;
    logic illegal_c;
    logic wait_state;
    logic timeout;

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                        (state_q == S_MEMWRITE);
    assign timeout    = TIMEOUT_EN && wait_state && !mem_ready &&
                        (stall_q == STALL_LAST);

    // -------------------------------------------------------------------------
    // Next-state and Moore output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path through the case statement can leave a latch behind.
        state_d     = state_q;
        alu_op      = ALU_ADD;
        alu_src_a   = A_PC;
        alu_src_b   = B_RS2;
        result_src  = RES_ALUOUT;
        adr_src     = 1'b0;
        ir_write_c  = 1'b0;
        pc_update_c = 1'b0;
        branch_c    = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        done_c      = 1'b0;
        illegal_c   = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                alu_src_a  = A_PC;
                alu_src_b  = B_FOUR;
                alu_op     = ALU_ADD;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write_c  = 1'b1;
                    pc_update_c = 1'b1;
                    state_d     = S_DECODE;
                end
            end

            S_DECODE: begin
                // Precompute the branch/jump target as oldPC + imm.
                alu_src_a = A_OLDPC;
                alu_src_b = B_IMM;
                alu_op    = ALU_ADD;
                unique case (opcode)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECR;
                    OP_ITYPE:  state_d = S_EXECI;
                    OP_BRANCH: state_d = S_BEQ;
                    OP_JAL:    state_d = S_JAL;
                    default: begin
                        illegal_c = 1'b1;
                        done_c    = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
                alu_op    = ALU_ADD;
                // opcode[5] separates store (0100011) from load (0000011).
                state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end

            S_MEMWB: begin
                result_src  = RES_MEM;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end

            S_MEMWRITE: begin
                adr_src     = 1'b1;
                result_src  = RES_ALUOUT;
                mem_write_c = 1'b1;
                if (mem_ready) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_EXECR: begin
                alu_src_a = A_RS1;
                alu_src_b = B_RS2;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALUWB;
            end

            S_EXECI: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALUWB;
            end

            S_ALUWB: begin
                result_src  = RES_ALUOUT;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end

            S_BEQ: begin
                // Compare rs1 - rs2; ALUOut still holds the target from DECODE.
                alu_src_a  = A_RS1;
                alu_src_b  = B_RS2;
                alu_op     = ALU_SUB;
                result_src = RES_ALUOUT;
                branch_c   = 1'b1;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end

            S_JAL: begin
                // PC <- target (ALUOut); ALU forms oldPC + 4 for the link.
                alu_src_a   = A_OLDPC;
                alu_src_b   = B_FOUR;
                alu_op      = ALU_ADD;
                result_src  = RES_ALUOUT;
                pc_update_c = 1'b1;
                state_d     = S_ALUWB;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A stall timeout abandons the access: nothing is written, the
        // instruction is retired as faulted and the FSM refetches.
        if (timeout) begin
            ir_write_c  = 1'b0;
            pc_update_c = 1'b0;
            branch_c    = 1'b0;
            reg_write_c = 1'b0;
            mem_write_c = 1'b0;
            done_c      = 1'b1;
            state_d     = S_FETCH;
        end
    end

    // -------------------------------------------------------------------------
    // Stall counter
    // -------------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (!wait_state || mem_ready || timeout || (state_d != state_q)) begin
            stall_d = '0;
        end else if (stall_q != '1) begin
            // Saturates rather than wrapping when the timeout is disabled.
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // NOTE: the enables are combinational (FETCH also depends on mem_ready),
    // so they are masked with rst_n to drop the instant reset asserts instead
    // of waiting for the state register alone.
    assign ir_write   = rst_n & ir_write_c;
    assign pc_write   = rst_n & (pc_update_c | (branch_c & zero));
    assign reg_write  = rst_n & reg_write_c;
    assign mem_write  = rst_n & mem_write_c;
    assign instr_done = rst_n & done_c;
    assign illegal_op = rst_n & illegal_c;
    assign mem_err    = rst_n & timeout;
    assign state_dbg  = state_q;

endmodule
